// File: rtl/input_conditioner.sv
// Conditions three raw asynchronous levels: each channel is synchronised, debounced
// into a stable level, and the stable level is edge-detected into one-cycle pulses.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    output logic A_OUT,
    output logic B_OUT,
    output logic C_OUT,
    output logic A_RISE,
    output logic B_RISE,
    output logic C_RISE,
    output logic A_FALL,
    output logic B_FALL,
    output logic C_FALL
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] stable;
    logic [2:0] rise;
    logic [2:0] fall;

    assign raw = {C, B, A};

    // Only sync1 touches the raw pins; everything downstream uses sync2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_chan
        logic [CNT_W-1:0] cnt_q;
        logic             stable_q;
        logic             rise_q;
        logic             fall_q;

        // Counter runs only while sync2 disagrees with the stable level and
        // restarts from zero on any agreement or on a completed flip.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync2[i] == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q    <= '0;
                    stable_q <= sync2[i];
                    rise_q   <= sync2[i];
                    fall_q   <= ~sync2[i];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        assign stable[i] = stable_q;
        assign rise[i]   = rise_q;
        assign fall[i]   = fall_q;
    end

    assign A_OUT  = stable[0];
    assign B_OUT  = stable[1];
    assign C_OUT  = stable[2];
    assign A_RISE = rise[0];
    assign B_RISE = rise[1];
    assign C_RISE = rise[2];
    assign A_FALL = fall[0];
    assign B_FALL = fall[1];
    assign C_FALL = fall[2];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random bouncing inputs,
// checked every cycle against a window-based reference model.
module tb_input_conditioner;

    localparam int D = 4;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b1;
    logic A = 1'b0, B = 1'b0, C = 1'b0;
    logic A_OUT, B_OUT, C_OUT, A_RISE, B_RISE, C_RISE, A_FALL, B_FALL, C_FALL;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    int rise_cnt[3] = '{0, 0, 0};
    int fall_cnt[3] = '{0, 0, 0};

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C),
        .A_OUT(A_OUT), .B_OUT(B_OUT), .C_OUT(C_OUT),
        .A_RISE(A_RISE), .B_RISE(B_RISE), .C_RISE(C_RISE),
        .A_FALL(A_FALL), .B_FALL(B_FALL), .C_FALL(C_FALL)
    );

    // clock / reset
    always #5 if (clk_en) clk = ~clk;

    wire [8:0] dut_o = {C_FALL, B_FALL, A_FALL, C_RISE, B_RISE, A_RISE, C_OUT, B_OUT, A_OUT};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw is seen two edges late; a channel's level flips once
    // the last D delayed samples all disagree with it.
    bit [2:0] s1_m, s2_m, st_m, rise_m, fall_m;
    bit [2:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_m = '0; s2_m = '0; st_m = '0; rise_m = '0; fall_m = '0;
            hist.delete();
        end else begin
            hist.push_back(s2_m);
            if (hist.size() > D) void'(hist.pop_front());
            rise_m = '0;
            fall_m = '0;
            if (hist.size() == D) begin
                for (int i = 0; i < 3; i++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][i] == st_m[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        st_m[i] = ~st_m[i];
                        if (st_m[i]) rise_m[i] = 1'b1;
                        else fall_m[i] = 1'b1;
                    end
                end
            end
            s2_m = s1_m;
            s1_m = {C, B, A};
        end
    end

    // scoreboard: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("outs", {23'd0, dut_o}, {23'd0, fall_m, rise_m, st_m});
            for (int i = 0; i < 3; i++) begin
                if (dut_o[3 + i]) rise_cnt[i]++;
                if (dut_o[6 + i]) fall_cnt[i]++;
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic [2:0] v);
        {C, B, A} = v;
    endtask

    initial begin
        int r0, f0;
        // 1. async reset with clock stopped
        set_raw(3'b111);
        #3 rst_n = 1'b0;
        #1 check("reset_outs", {23'd0, dut_o}, 32'd0);
        clk_en = 1'b1;
        cycles(3);
        set_raw(3'b000);
        rst_n = 1'b1;
        chk_en = 1'b1;
        cycles(8);

        // 2. clean step on A
        set_raw(3'b001);
        cycles(5);
        check("step_a_before", {31'd0, A_OUT}, 32'd0);
        cycles(1);
        check("step_a_out", {30'd0, A_OUT, A_RISE}, 32'd3);
        cycles(1);
        check("step_a_rise_gone", {30'd0, A_OUT, A_RISE}, 32'd2);

        // 3. bounce on B
        r0 = rise_cnt[1];
        B = 1'b1; cycles(2);
        B = 1'b0; cycles(2);
        B = 1'b1; cycles(2);
        B = 1'b0; cycles(2);
        B = 1'b1;
        cycles(5);
        check("bounce_b_before", {31'd0, B_OUT}, 32'd0);
        cycles(1);
        check("bounce_b_out", {31'd0, B_OUT}, 32'd1);
        cycles(6);
        check("bounce_b_one_rise", rise_cnt[1] - r0, 32'd1);

        // 4. glitch on C
        r0 = rise_cnt[2];
        f0 = fall_cnt[2];
        C = 1'b1; cycles(3);
        C = 1'b0; cycles(10);
        check("glitch_c_out", {31'd0, C_OUT}, 32'd0);
        check("glitch_c_pulses", (rise_cnt[2] - r0) + (fall_cnt[2] - f0), 32'd0);

        // 5. simultaneous fall
        set_raw(3'b111);
        cycles(10);
        check("simul_all_high", {29'd0, C_OUT, B_OUT, A_OUT}, 32'd7);
        set_raw(3'b000);
        cycles(6);
        check("simul_falls", {29'd0, C_FALL, B_FALL, A_FALL}, 32'd7);
        cycles(4);

        // 6. reset mid-count
        A = 1'b1;
        cycles(3);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        cycles(5);
        check("rst_mid_before", {31'd0, A_OUT}, 32'd0);
        cycles(1);
        check("rst_mid_out", {30'd0, A_OUT, A_RISE}, 32'd3);
        cycles(4);

        // random bouncing on all channels
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 4) == 0) begin
                    case (i)
                        0: A = ~A;
                        1: B = ~B;
                        default: C = ~C;
                    endcase
                end
            if (n == 300) begin
                #2 rst_n = 1'b0;
                #3 rst_n = 1'b1;
            end
            cycles(1);
        end
        cycles(12);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
